// File: rtl/dc_rm_pkg.sv
// Shared types and defaults for the RX DC-removal sequencing controller.
package dc_rm_pkg;

  localparam int DC_DATA_WIDTH   = 16;
  localparam int DC_LOG2_AVG_LEN = 7;
  localparam int DC_NUM_LANES    = 2;  // lane 0 = I, lane 1 = Q

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } dc_state_e;

endpackage

// File: rtl/dc_sub_sat.sv
// One lane of DC correction: y = a - b on signed samples.
// DC_RM_CTRL_SAT_EN selects saturation; otherwise the result wraps.
module dc_sub_sat #(
  parameter int DATA_WIDTH = 16
)(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

`ifdef DC_RM_CTRL_SAT_EN
  logic [DATA_WIDTH:0] diff;

  assign diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};

  // Overflow iff the two top bits of the widened difference disagree.
  always_comb begin
    y = diff[DATA_WIDTH-1:0];
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1])
      y = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  // Truncating the widened difference equals a plain DATA_WIDTH-bit subtract.
  assign y = a - b;
`endif

endmodule

// File: rtl/dc_rm_ctrl.sv
// RX DC-removal sequencing: chooses which DC estimate is subtracted per sample
// (zero, live average, or frozen snapshot). Optional macro: DC_RM_CTRL_SAT_EN.
module dc_rm_ctrl
  import dc_rm_pkg::*;
#(
  parameter int DATA_WIDTH    = DC_DATA_WIDTH,
  parameter int LOG2_AVG_LEN  = DC_LOG2_AVG_LEN,
  parameter int TIMEOUT_WIDTH = 16
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_WIDTH-1:0]    ddc_i,
  input  logic [DATA_WIDTH-1:0]    ddc_q,
  input  logic                     ddc_iq_valid,
  input  logic [DATA_WIDTH-1:0]    avg_i,
  input  logic [DATA_WIDTH-1:0]    avg_q,
  input  logic                     pkt_start,
  input  logic                     pkt_end,
  input  logic                     freeze_en,
  input  logic [TIMEOUT_WIDTH-1:0] hold_timeout,
  output logic [DATA_WIDTH-1:0]    i_dc_rm,
  output logic [DATA_WIDTH-1:0]    q_dc_rm,
  output logic                     iq_dc_rm_valid,
  output logic [DATA_WIDTH-1:0]    dc_est_i,
  output logic [DATA_WIDTH-1:0]    dc_est_q,
  output logic [1:0]               dc_state,
  output logic                     hold_timeout_flag
);

  localparam int NUM_LANES = DC_NUM_LANES;
  localparam int CNT_W     = (TIMEOUT_WIDTH > LOG2_AVG_LEN) ? TIMEOUT_WIDTH : LOG2_AVG_LEN;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << LOG2_AVG_LEN) - 1);

  dc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             to_hit;
  logic             start_q;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] raw, avg, est_q, est_use, res, res_q;

  assign raw     = {ddc_q, ddc_i};
  assign avg     = {avg_q, avg_i};
  assign cnt_inc = cnt + 1'b1;
  assign start_q = pkt_start & freeze_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= WARMUP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pulses are looked at every cycle; only valid samples move the counters.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_hit    = 1'b0;
    case (state)
      WARMUP: begin
        if (ddc_iq_valid) begin
          if (cnt == WIN_LAST) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      TRACK: begin
        if (start_q) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (!freeze_en) begin
          if (ddc_iq_valid) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
          end
        end else if (pkt_end) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else if (ddc_iq_valid) begin
          if (hold_timeout != '0 && cnt_inc == CNT_W'(hold_timeout)) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
            to_hit    = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      SETTLE: begin
        if (start_q) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (!freeze_en) begin
          if (ddc_iq_valid) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
          end
        end else if (ddc_iq_valid) begin
          if (cnt == WIN_LAST) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = WARMUP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // In TRACK the live average applies to the very sample it arrives with.
  always_comb begin
    case (state)
      WARMUP:  est_use = '0;
      TRACK:   est_use = avg;
      default: est_use = est_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      est_q <= '0;
    else if (state == TRACK && ddc_iq_valid)
      est_q <= avg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      hold_timeout_flag <= 1'b0;
    else if (to_hit)
      hold_timeout_flag <= 1'b1;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dc_sub_sat #(.DATA_WIDTH(DATA_WIDTH)) u_sub (
      .a (raw[l]),
      .b (est_use[l]),
      .y (res[l])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q          <= '0;
      iq_dc_rm_valid <= 1'b0;
    end else begin
      iq_dc_rm_valid <= ddc_iq_valid;
      if (ddc_iq_valid)
        res_q <= res;
    end
  end

  assign i_dc_rm  = res_q[0];
  assign q_dc_rm  = res_q[1];
  assign dc_est_i = est_q[0];
  assign dc_est_q = est_q[1];
  assign dc_state = state;

endmodule

// File: tb/tb_dc_rm_ctrl.sv
// Directed and randomized checks of dc_rm_ctrl against a sample-level reference model.
module tb_dc_rm_ctrl;

  localparam int N   = 128;
  localparam int WU  = 0;
  localparam int TRK = 1;
  localparam int HLD = 2;
  localparam int STL = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ddc_i, ddc_q, avg_i, avg_q;
  logic        ddc_iq_valid, pkt_start, pkt_end, freeze_en;
  logic [15:0] hold_timeout;
  logic [15:0] i_dc_rm, q_dc_rm, dc_est_i, dc_est_q;
  logic        iq_dc_rm_valid, hold_timeout_flag;
  logic [1:0]  dc_state;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          ms, mn;
  logic [15:0] me_i, me_q, eo_i, eo_q;
  logic        eo_v, mflag;

  always #5 clk = ~clk;

  dc_rm_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ddc_i(ddc_i), .ddc_q(ddc_q), .ddc_iq_valid(ddc_iq_valid),
    .avg_i(avg_i), .avg_q(avg_q),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .freeze_en(freeze_en),
    .hold_timeout(hold_timeout),
    .i_dc_rm(i_dc_rm), .q_dc_rm(q_dc_rm), .iq_dc_rm_valid(iq_dc_rm_valid),
    .dc_est_i(dc_est_i), .dc_est_q(dc_est_q),
    .dc_state(dc_state), .hold_timeout_flag(hold_timeout_flag)
  );

  function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    int d;
    d = $signed(a) - $signed(b);
`ifdef DC_RM_CTRL_SAT_EN
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
`endif
    return d[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ms = WU; mn = 0; me_i = '0; me_q = '0;
    eo_i = '0; eo_q = '0; eo_v = 1'b0; mflag = 1'b0;
  endtask

  task automatic check_all();
    chk("i_dc_rm",  i_dc_rm,  eo_i);
    chk("q_dc_rm",  q_dc_rm,  eo_q);
    chk("valid",    {15'd0, iq_dc_rm_valid}, {15'd0, eo_v});
    chk("est_i",    dc_est_i, me_i);
    chk("est_q",    dc_est_q, me_q);
    chk("state",    {14'd0, dc_state}, ms[15:0]);
    chk("flag",     {15'd0, hold_timeout_flag}, {15'd0, mflag});
  endtask

  // One clock: model consumes the current inputs, then DUT outputs are compared.
  task automatic step();
    logic [15:0] ui, uq;
    if (ddc_iq_valid) begin
      ui = (ms == TRK) ? avg_i : (ms == WU) ? 16'd0 : me_i;
      uq = (ms == TRK) ? avg_q : (ms == WU) ? 16'd0 : me_q;
      eo_i = ref_sub(ddc_i, ui);
      eo_q = ref_sub(ddc_q, uq);
      if (ms == TRK) begin me_i = avg_i; me_q = avg_q; end
    end
    eo_v = ddc_iq_valid;
    case (ms)
      WU:  if (ddc_iq_valid) begin mn++; if (mn == N) begin ms = TRK; mn = 0; end end
      TRK: if (pkt_start && freeze_en) begin ms = HLD; mn = 0; end
      HLD: begin
        if (!freeze_en) begin
          if (ddc_iq_valid) begin ms = TRK; mn = 0; end
        end else if (pkt_end) begin
          ms = STL; mn = 0;
        end else if (ddc_iq_valid) begin
          mn++;
          if (hold_timeout != 0 && mn == int'(hold_timeout)) begin ms = STL; mn = 0; mflag = 1'b1; end
        end
      end
      default: begin
        if (pkt_start && freeze_en) begin
          ms = HLD; mn = 0;
        end else if (!freeze_en) begin
          if (ddc_iq_valid) begin ms = TRK; mn = 0; end
        end else if (ddc_iq_valid) begin
          mn++;
          if (mn == N) begin ms = TRK; mn = 0; end
        end
      end
    endcase
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic samples(input int n, input logic [15:0] di, input logic [15:0] ai);
    for (int k = 0; k < n; k++) begin
      ddc_iq_valid = 1'b1; ddc_i = di; avg_i = ai;
      ddc_q = 16'($urandom); avg_q = 16'($urandom);
      step();
    end
    ddc_iq_valid = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic e);
    pkt_start = s; pkt_end = e; ddc_iq_valid = 1'b0;
    step();
    pkt_start = 1'b0; pkt_end = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; ddc_i = '0; ddc_q = '0; avg_i = '0; avg_q = '0;
    ddc_iq_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0;
    freeze_en = 1'b1; hold_timeout = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;

    // warm-up: 128 samples with estimate 0, then live tracking
    samples(N - 1, 16'd100, 16'd40);
    chk("warm_state", {14'd0, dc_state}, 16'd0);
    samples(1, 16'd100, 16'd40);
    chk("warm_last_out", i_dc_rm, 16'd100);
    chk("warm_to_track", {14'd0, dc_state}, 16'd1);
    samples(1, 16'd100, 16'd40);
    chk("first_track_out", i_dc_rm, 16'd60);

    // freeze through a packet, settle, resume
    pulse(1'b1, 1'b0);
    samples(20, 16'd520, 16'd500);
    chk("hold_est", dc_est_i, 16'd40);
    chk("hold_out", i_dc_rm, 16'd480);
    pulse(1'b0, 1'b1);
    chk("settle_entry", {14'd0, dc_state}, 16'd3);
    samples(N, 16'd520, 16'd500);
    chk("settle_out", i_dc_rm, 16'd480);
    chk("settle_done", {14'd0, dc_state}, 16'd1);
    samples(1, 16'd520, 16'd500);
    chk("resume_est", dc_est_i, 16'd500);
    chk("resume_out", i_dc_rm, 16'd20);

    // hold timeout after 10 samples
    hold_timeout = 16'd10;
    pulse(1'b1, 1'b0);
    samples(9, 16'd7, 16'd3);
    chk("to_pending", {14'd0, dc_state}, 16'd2);
    samples(1, 16'd7, 16'd3);
    chk("to_settle", {14'd0, dc_state}, 16'd3);
    chk("to_flag", {15'd0, hold_timeout_flag}, 16'd1);
    freeze_en = 1'b0; samples(1, 16'd7, 16'd3); freeze_en = 1'b1;
    chk("unfreeze", {14'd0, dc_state}, 16'd1);

    // no timeout when hold_timeout is zero
    hold_timeout = 16'd0;
    pulse(1'b1, 1'b0);
    samples(1005, 16'd9, 16'd4);
    chk("no_timeout", {14'd0, dc_state}, 16'd2);

    // simultaneous pulses and restart from SETTLE
    pulse(1'b1, 1'b1);
    chk("hold_pair", {14'd0, dc_state}, 16'd3);
    samples(5, 16'd11, 16'd33);
    pulse(1'b1, 1'b0);
    chk("settle_restart", {14'd0, dc_state}, 16'd2);
    chk("settle_restart_est", dc_est_i, 16'd500);
    freeze_en = 1'b0; samples(1, 16'd11, 16'd33); freeze_en = 1'b1;
    pulse(1'b1, 1'b1);
    chk("track_pair", {14'd0, dc_state}, 16'd2);
    freeze_en = 1'b0; samples(1, 16'd11, 16'd33); freeze_en = 1'b1;

    // subtraction overflow at the negative rail
    samples(1, 16'h8000, 16'd1);
`ifdef DC_RM_CTRL_SAT_EN
    chk("sat_edge", i_dc_rm, 16'h8000);
`else
    chk("wrap_edge", i_dc_rm, 16'h7fff);
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      ddc_iq_valid = ($urandom_range(0, 3) != 0);
      pkt_start    = ($urandom_range(0, 149) == 0);
      pkt_end      = ($urandom_range(0, 19) == 0);
      freeze_en    = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 199) == 0)
        hold_timeout = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      ddc_i = 16'($urandom); ddc_q = 16'($urandom);
      avg_i = 16'($urandom); avg_q = 16'($urandom);
      step();
    end
    pkt_start = 1'b0; pkt_end = 1'b0; freeze_en = 1'b1; ddc_iq_valid = 1'b0;

    // asynchronous reset in the middle of HOLD
    hold_timeout = 16'd0;
    freeze_en = 1'b0; samples(1, 16'd5, 16'd2); freeze_en = 1'b1;
    pulse(1'b1, 1'b0);
    samples(3, 16'd5, 16'd2);
    chk("pre_reset_hold", {14'd0, dc_state}, 16'd2);
    #2; rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_i", i_dc_rm, 16'd0);
    chk("rst_valid", {15'd0, iq_dc_rm_valid}, 16'd0);
    chk("rst_est", dc_est_i, 16'd0);
    chk("rst_state", {14'd0, dc_state}, 16'd0);
    chk("rst_flag", {15'd0, hold_timeout_flag}, 16'd0);
    rstn = 1'b1;
    samples(N - 1, 16'd50, 16'd8);
    chk("rewarm_state", {14'd0, dc_state}, 16'd0);
    samples(1, 16'd50, 16'd8);
    chk("rewarm_done", {14'd0, dc_state}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
